// File: rtl/main_memory_pkg.sv
// Shared types and constants for the line-organised main memory.
// Holds the FSM state encoding, line width and latency-counter width.
package main_memory_pkg;

   localparam int LINE_BITS = 128;
   localparam int CNT_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WAIT,
      ST_RESP,
      ST_DRAIN
   } state_t;

endpackage

// File: rtl/mem_line_array.sv
// Single-port synchronous line RAM, one line per address.
// Read data is registered and only changes on a read access.
module mem_line_array
   import main_memory_pkg::*;
#(
   parameter int DEPTH_LINES = 4096,
   parameter int IDX_W       = 12
) (
   input  logic                 i_clk,
   input  logic                 i_en,
   input  logic                 i_we,
   input  logic [IDX_W-1:0]     i_addr,
   input  logic [LINE_BITS-1:0] i_data,
   output logic [LINE_BITS-1:0] o_data
);

   logic [LINE_BITS-1:0] r_mem [DEPTH_LINES];
   logic [LINE_BITS-1:0] r_q;

   // one access per enabled edge: write a full line or latch a read
   always_ff @(posedge i_clk) begin
      if (i_en) begin
         if (i_we) begin
            r_mem[i_addr] <= i_data;
         end else begin
            r_q <= r_mem[i_addr];
         end
      end
   end

   assign o_data = r_q;

endmodule

// File: rtl/main_memory.sv
// Fixed-latency line memory behind a valid-pulse system bus.
// Optional range checking is enabled by MAIN_MEMORY_BOUNDS_CHECK_EN.
module main_memory
   import main_memory_pkg::*;
#(
   parameter int BUS_ADDRESS_WIDTH    = 20,
   parameter int BUS_DATA_WIDTH_SHIFT = 4,
   parameter int LATENCY              = 4,
   parameter int DEPTH_LINES          = 4096
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] bus_addr_i,
   input  logic [LINE_BITS-1:0] bus_data_i,
   input  logic                 bus_we_i,
   input  logic                 bus_valid_i,
   output logic [LINE_BITS-1:0] bus_data_o,
   output logic                 bus_valid_o,
   output logic                 err_o
);

   localparam int LA_W  = BUS_ADDRESS_WIDTH - BUS_DATA_WIDTH_SHIFT;
   localparam int IDX_W = $clog2(DEPTH_LINES);
   localparam bit DIRECT = (LATENCY == 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t               r_state;
   logic [CNT_W-1:0]     r_cnt;
   logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] r_addr;
   logic [LINE_BITS-1:0] r_wdata;
   logic                 r_we;
   logic [LINE_BITS-1:0] r_rdata;
   logic                 r_valid;
   logic                 r_err;

   logic [BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT] w_addr;
   logic [LINE_BITS-1:0] w_wdata;
   logic                 w_we;
   logic                 w_acc;
   logic                 w_oob_acc;
   logic                 w_oob_cap;
   logic [IDX_W-1:0]     w_idx;
   logic [LINE_BITS-1:0] w_rd;

   // With LATENCY=1 the array is hit on the accepting edge itself,
   // so the live bus fields stand in for the not-yet-captured ones.
   assign w_addr  = (r_state == ST_IDLE) ? bus_addr_i : r_addr;
   assign w_wdata = (r_state == ST_IDLE) ? bus_data_i : r_wdata;
   assign w_we    = (r_state == ST_IDLE) ? bus_we_i   : r_we;
   assign w_idx   = w_addr[BUS_DATA_WIDTH_SHIFT +: IDX_W];

   // Access one edge before the response so the registered RAM
   // output is ready when the response registers load.
   assign w_acc = ~rst_i &
                  ((DIRECT && r_state == ST_IDLE && bus_valid_i) ||
                   (r_state == ST_WAIT && r_cnt == CNT_ONE));

`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
   if (LA_W > IDX_W) begin : g_hi
      assign w_oob_acc =
         |w_addr[BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT+IDX_W];
      assign w_oob_cap =
         |r_addr[BUS_ADDRESS_WIDTH-1:BUS_DATA_WIDTH_SHIFT+IDX_W];
   end else begin : g_nohi
      assign w_oob_acc = 1'b0;
      assign w_oob_cap = 1'b0;
   end
`else
   logic w_unused_addr;
   assign w_oob_acc     = 1'b0;
   assign w_oob_cap     = 1'b0;
   assign w_unused_addr = ^w_addr;
`endif

   mem_line_array #(
      .DEPTH_LINES (DEPTH_LINES),
      .IDX_W       (IDX_W)
   ) u_array (
      .i_clk  (clk_i),
      .i_en   (w_acc),
      .i_we   (w_we & ~w_oob_acc),
      .i_addr (w_idx),
      .i_data (w_wdata),
      .o_data (w_rd)
   );

   // request FSM: capture, count down latency, respond, drain
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_valid <= 1'b0;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         r_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus_valid_i) begin
                  r_addr  <= bus_addr_i;
                  r_wdata <= bus_data_i;
                  r_we    <= bus_we_i;
                  r_cnt   <= CNT_LOAD;
                  r_state <= DIRECT ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               r_cnt <= r_cnt - CNT_ONE;
               if (r_cnt == CNT_ONE) begin
                  r_state <= ST_RESP;
               end
            end
            ST_RESP: begin
               r_valid <= 1'b1;
               r_err   <= w_oob_cap;
               if (!r_we) begin
                  r_rdata <= w_oob_cap ? '0 : w_rd;
               end
               r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_data_o  = r_rdata;
   assign bus_valid_o = r_valid;
   assign err_o       = r_err;

endmodule

// File: tb/tb_main_memory.sv
// Scoreboard bench: LATENCY=4 / 4096-line instance plus a LATENCY=1
// instance; responses are predicted from a line-array model.
module tb_main_memory;

   localparam int LAT0 = 4;
   localparam int DEP0 = 4096;
   localparam int LAT1 = 1;
   localparam int DEP1 = 16;
`ifdef MAIN_MEMORY_BOUNDS_CHECK_EN
   localparam bit BC = 1'b1;
`else
   localparam bit BC = 1'b0;
`endif

   typedef struct {
      int           cyc;
      logic [127:0] data;
      bit           err;
   } exp_t;

   logic clk;
   logic rst;
   logic [15:0]  addr0, addr1;
   logic [127:0] wd0, wd1, od0, od1;
   logic         we0, we1, v0, v1, ov0, ov1, oe0, oe1;

   int cyc;
   int checks;
   int errors;
   bit in_drain;
   exp_t q0[$];
   exp_t q1[$];
   exp_t m0, m1;
   logic [127:0] mem0 [int];
   logic [127:0] mem1 [int];
   logic [127:0] last0, last1;
   logic [15:0]  pool[$];

   main_memory #(
      .BUS_ADDRESS_WIDTH(20), .BUS_DATA_WIDTH_SHIFT(4),
      .LATENCY(LAT0), .DEPTH_LINES(DEP0)
   ) dut0 (
      .clk_i(clk), .rst_i(rst), .bus_addr_i(addr0),
      .bus_data_i(wd0), .bus_we_i(we0), .bus_valid_i(v0),
      .bus_data_o(od0), .bus_valid_o(ov0), .err_o(oe0)
   );

   main_memory #(
      .BUS_ADDRESS_WIDTH(20), .BUS_DATA_WIDTH_SHIFT(4),
      .LATENCY(LAT1), .DEPTH_LINES(DEP1)
   ) dut1 (
      .clk_i(clk), .rst_i(rst), .bus_addr_i(addr1),
      .bus_data_i(wd1), .bus_we_i(we1), .bus_valid_i(v1),
      .bus_data_o(od1), .bus_valid_o(ov1), .err_o(oe1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: got %h, required %h", nm, act, exp);
      end
   endtask

   // Behavioural line memory: index wraps modulo depth; with range
   // checking, out-of-range lines are not written and read as zero.
   task automatic model(input bit sel, input bit we,
                        input logic [15:0] a, input logic [127:0] d,
                        output logic [127:0] od, output bit oe);
      int depth;
      int idx;
      bit oob;
      depth = sel ? DEP1 : DEP0;
      idx = int'(a) % depth;
      oob = BC && (int'(a) >= depth);
      if (we) begin
         if (!oob) begin
            if (sel) mem1[idx] = d;
            else     mem0[idx] = d;
         end
         od = sel ? last1 : last0;
      end else begin
         if (oob)      od = '0;
         else if (sel) od = mem1[idx];
         else          od = mem0[idx];
         if (sel) last1 = od;
         else     last0 = od;
      end
      oe = oob;
   endtask

   always @(negedge clk) begin
      if (ov0) begin
         if (q0.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL spurious0: bus_valid_o=1, required 0");
         end else begin
            m0 = q0.pop_front();
            chk("latency0", 128'(cyc), 128'(m0.cyc));
            chk("data0", od0, m0.data);
            chk("err0", 128'(oe0), 128'(m0.err));
         end
      end
   end

   always @(negedge clk) begin
      if (ov1) begin
         if (q1.size() == 0) begin
            checks = checks + 1;
            errors = errors + 1;
            $display("FAIL spurious1: bus_valid_o=1, required 0");
         end else begin
            m1 = q1.pop_front();
            chk("latency1", 128'(cyc), 128'(m1.cyc));
            chk("data1", od1, m1.data);
            chk("err1", 128'(oe1), 128'(m1.err));
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
      v0 = 1'b0;
      in_drain = 1'b0;
   endtask

   // mode 0: plain, 1: hold valid one extra cycle, 2: scramble inputs
   // after acceptance while waiting for the response
   task automatic req(input bit we, input logic [15:0] a,
                      input logic [127:0] d, input int mode);
      exp_t e;
      int acc;
      bit got;
      v0 = 1'b1; we0 = we; addr0 = a; wd0 = d;
      acc = cyc + (in_drain ? 2 : 1);
      e.cyc = acc + LAT0;
      model(1'b0, we, a, d, e.data, e.err);
      q0.push_back(e);
      got = 1'b0;
      for (int t = 0; t < 40 && !got; t++) begin
         @(negedge clk);
         if (ov0) got = 1'b1;
         else if (mode == 2 && cyc >= acc) begin
            addr0 = 16'($urandom);
            wd0 = {$urandom, $urandom, $urandom, $urandom};
            we0 = 1'($urandom);
            v0 = 1'($urandom);
         end
      end
      if (!got) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout0: got no response, required one");
         q0.delete();
      end
      if (mode == 1) begin
         v0 = 1'b1; we0 = we; addr0 = a; wd0 = d;
         @(negedge clk);
      end
      v0 = 1'b0;
      we0 = 1'b0;
      addr0 = 16'($urandom);
      in_drain = got && (mode != 1);
   endtask

   task automatic abort_write(input logic [15:0] a,
                              input logic [127:0] d);
      if (in_drain) idle(1);
      v0 = 1'b1; we0 = 1'b1; addr0 = a; wd0 = d;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      v0 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", 128'(ov0), 128'(0));
      chk("rst_data", od0, '0);
      chk("rst_err", 128'(oe0), 128'(0));
      last0 = '0;
      last1 = '0;
      idle(8);
   endtask

   task automatic req1(input bit we, input logic [15:0] a,
                       input logic [127:0] d);
      exp_t e;
      bit got;
      v1 = 1'b1; we1 = we; addr1 = a; wd1 = d;
      e.cyc = cyc + 1 + LAT1;
      model(1'b1, we, a, d, e.data, e.err);
      q1.push_back(e);
      got = 1'b0;
      for (int t = 0; t < 10 && !got; t++) begin
         @(negedge clk);
         if (ov1) got = 1'b1;
      end
      if (!got) begin
         checks = checks + 1;
         errors = errors + 1;
         $display("FAIL timeout1: got no response, required one");
         q1.delete();
      end
      @(negedge clk);
      v1 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: got no finish, required finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d;
      logic [15:0] a;
      cyc = 0; checks = 0; errors = 0; in_drain = 1'b0;
      last0 = '0; last1 = '0;
      rst = 1'b1;
      v0 = 0; we0 = 0; addr0 = '0; wd0 = '0;
      v1 = 0; we1 = 0; addr1 = '0; wd1 = '0;
      repeat (3) @(negedge clk);
      chk("reset_valid", 128'(ov0), 128'(0));
      chk("reset_data", od0, '0);
      chk("reset_err", 128'(oe0), 128'(0));
      chk("reset_data1", od1, '0);
      rst = 1'b0;
      idle(2);

      d = 128'h0123456789ABCDEF0123456789ABCDEF;
      req(1'b1, 16'h0010, d, 0);
      req(1'b0, 16'h0010, '0, 0);
      idle(1);
      req(1'b1, 16'h0020, {8{16'hAAAA}}, 0);
      abort_write(16'h0020, {4{32'hDEADBEEF}});
      req(1'b0, 16'h0020, '0, 1);
      req(1'b1, 16'h0005, {4{32'h12345678}}, 0);
      req(1'b1, 16'h1005, {8{16'h5555}}, 0);
      req(1'b0, 16'h0005, '0, 0);
      req(1'b0, 16'h1005, '0, 0);
      req(1'b0, 16'h0010, '0, 2);
      idle(2);

      pool.push_back(16'h0010);
      pool.push_back(16'h0020);
      pool.push_back(16'h0005);
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom_range(0, DEP0 - 1));
         pool.push_back(a);
      end
      foreach (pool[i]) begin
         d = {$urandom, $urandom, $urandom, $urandom};
         req(1'b1, pool[i], d, 0);
      end
      pool.push_back(16'h1010);
      pool.push_back(16'h2020);
      pool.push_back(16'hF005);
      for (int i = 0; i < 150; i++) begin
         int g;
         g = $urandom_range(0, 2);
         if (g > 0) idle(g);
         a = pool[$urandom_range(0, pool.size() - 1)];
         d = {$urandom, $urandom, $urandom, $urandom};
         req(1'($urandom), a, d, $urandom_range(0, 2));
      end
      idle(6);

      d = {$urandom, $urandom, $urandom, $urandom};
      req1(1'b1, 16'h0003, d);
      req1(1'b0, 16'h0003, '0);
      req1(1'b1, 16'h0007, {4{32'hCAFEF00D}});
      req1(1'b0, 16'h0007, '0);
      req1(1'b0, 16'h0013, '0);
      repeat (4) @(negedge clk);

      chk("q0_drained", 128'(q0.size()), 128'(0));
      chk("q1_drained", 128'(q1.size()), 128'(0));
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
